// File: rtl/gpu_pkg.sv
// Shared types and defaults for the pixel arbiter slice.
// Pixel record at default geometry, arbiter state encoding, default clip limits.
// No logic; imported by gpu_pixel_fifo and gpu_pixel_arbiter.
package gpu_pkg;

  localparam int X_BITS_DEF    = 10;
  localparam int Y_BITS_DEF    = 9;
  localparam int CHAN_BITS_DEF = 8;
  localparam int X_MAX_DEF     = 639;
  localparam int Y_MAX_DEF     = 479;

  typedef struct packed {
    logic [X_BITS_DEF-1:0]    x;
    logic [Y_BITS_DEF-1:0]    y;
    logic [CHAN_BITS_DEF-1:0] r;
    logic [CHAN_BITS_DEF-1:0] g;
    logic [CHAN_BITS_DEF-1:0] b;
  } pixel_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2
  } arb_state_e;

endpackage

// File: rtl/gpu_pixel_fifo.sv
// Synchronous DEPTH-entry FIFO of flat pixel words with occupancy count.
// Latency: a pushed word is at the head the cycle after push when the FIFO was empty.
// Backpressure: none internally; caller must not push when full without popping.
// Ports: clk, n_rst, push/push_dat, pop, head_dat (word at read pointer), count.
module gpu_pixel_fifo
  import gpu_pkg::*;
#(
  parameter int WIDTH = 43,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_dat,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;

  // Storage is reset so the head outputs read zero out of reset.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= push_dat;
        wptr      <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head_dat = mem[rptr];

endmodule

// File: rtl/gpu_pixel_arbiter.sv
// Round-robin arbiter of N_ENGINES pixel writers into a FIFO toward memory; flush ordered after drain.
// Latency: granted pixel is at pix_*_o one cycle after acceptance; flush_o one cycle after FIFO empties.
// Backpressure: req_ready_o drops when FIFO full with no pop, and during DRAIN/FLUSH.
// Ports: clk, n_rst, req_valid_i/req_x_i/req_y_i/req_rgb_i/req_ready_o (per engine, packed),
//   flush_i, pix_valid_o/pix_ready_i/pix_x_o/pix_y_o/pix_rgb_o, flush_o, busy_o, fifo_count_o.
// Option: define GPU_PIXEL_CLIP_EN to drop out-of-range pixels and add clip_count_o.
module gpu_pixel_arbiter
  import gpu_pkg::*;
#(
  parameter int N_ENGINES = 4,
  parameter int X_BITS    = X_BITS_DEF,
  parameter int Y_BITS    = Y_BITS_DEF,
  parameter int CHAN_BITS = CHAN_BITS_DEF,
  parameter int DEPTH     = 8,
  parameter int X_MAX     = X_MAX_DEF,
  parameter int Y_MAX     = Y_MAX_DEF
) (
  input  logic                             clk,
  input  logic                             n_rst,
  input  logic [N_ENGINES-1:0]             req_valid_i,
  input  logic [N_ENGINES*X_BITS-1:0]      req_x_i,
  input  logic [N_ENGINES*Y_BITS-1:0]      req_y_i,
  input  logic [N_ENGINES*3*CHAN_BITS-1:0] req_rgb_i,
  output logic [N_ENGINES-1:0]             req_ready_o,
  input  logic                             flush_i,
  output logic                             pix_valid_o,
  input  logic                             pix_ready_i,
  output logic [X_BITS-1:0]                pix_x_o,
  output logic [Y_BITS-1:0]                pix_y_o,
  output logic [3*CHAN_BITS-1:0]           pix_rgb_o,
  output logic                             flush_o,
  output logic                             busy_o,
  output logic [$clog2(DEPTH):0]           fifo_count_o
`ifdef GPU_PIXEL_CLIP_EN
  ,
  output logic [15:0]                      clip_count_o
`endif
);

  localparam int RGBW = 3 * CHAN_BITS;
  localparam int PW   = X_BITS + Y_BITS + RGBW;
  localparam int CW   = $clog2(DEPTH) + 1;
  localparam int RRW  = $clog2(N_ENGINES);
`ifdef GPU_PIXEL_CLIP_EN
  localparam bit CLIP_ON = 1'b1;
`else
  localparam bit CLIP_ON = 1'b0;
`endif

  arb_state_e     state;
  logic [RRW-1:0] rr_ptr;
  logic [RRW-1:0] grant_idx;
  logic           grant_vld;
  logic           pop;
  logic           push;
  logic           room;
  logic           in_range;
  logic [X_BITS-1:0] g_x;
  logic [Y_BITS-1:0] g_y;
  logic [RGBW-1:0]   g_rgb;
  logic [PW-1:0]     head_dat;

  assign pix_valid_o = (fifo_count_o != '0);
  assign pop         = pix_valid_o & pix_ready_i;
  // A full FIFO can still take a pixel when the head leaves in the same cycle.
  assign room        = (fifo_count_o < CW'(DEPTH)) | pop;

  // Round-robin search starting at rr_ptr, wrapping modulo N_ENGINES.
  always_comb begin
    int idx;
    grant_vld = 1'b0;
    grant_idx = '0;
    idx       = 0;
    if (state == RUN && room) begin
      for (int i = 0; i < N_ENGINES; i++) begin
        idx = int'(rr_ptr) + i;
        if (idx >= N_ENGINES) idx = idx - N_ENGINES;
        if (!grant_vld && req_valid_i[idx]) begin
          grant_vld = 1'b1;
          grant_idx = RRW'(idx);
        end
      end
    end
  end

  assign req_ready_o = grant_vld ? ({{(N_ENGINES-1){1'b0}}, 1'b1} << grant_idx) : '0;

  assign g_x   = req_x_i[grant_idx*X_BITS +: X_BITS];
  assign g_y   = req_y_i[grant_idx*Y_BITS +: Y_BITS];
  assign g_rgb = req_rgb_i[grant_idx*RGBW +: RGBW];

  assign in_range = (32'(g_x) <= X_MAX) && (32'(g_y) <= Y_MAX);
  // Out-of-range pixels are still handshaken (ready, rr advance) but not stored when clipping.
  assign push     = grant_vld & (!CLIP_ON | in_range);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state   <= RUN;
      rr_ptr  <= '0;
      flush_o <= 1'b0;
    end else begin
      if (grant_vld)
        rr_ptr <= (int'(grant_idx) == N_ENGINES-1) ? '0 : grant_idx + 1'b1;
      flush_o <= 1'b0;
      case (state)
        RUN:   if (flush_i) state <= DRAIN;
        DRAIN: if (fifo_count_o == '0) begin
                 state   <= FLUSH;
                 flush_o <= 1'b1;
               end
        FLUSH: state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

  assign busy_o = pix_valid_o | (state != RUN);

  gpu_pixel_fifo #(
    .WIDTH (PW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .n_rst    (n_rst),
    .push     (push),
    .push_dat ({g_x, g_y, g_rgb}),
    .pop      (pop),
    .head_dat (head_dat),
    .count    (fifo_count_o)
  );

  assign {pix_x_o, pix_y_o, pix_rgb_o} = head_dat;

`ifdef GPU_PIXEL_CLIP_EN
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      clip_count_o <= '0;
    end else if (flush_o) begin
      clip_count_o <= '0;
    end else if (grant_vld && !in_range && clip_count_o != 16'hFFFF) begin
      clip_count_o <= clip_count_o + 16'd1;
    end
  end
`endif

endmodule

// File: doc/gpu_pixel_arbiter.md
Name: gpu_pixel_arbiter

Overview:
Parametrised successor to the fixed 4-engine combinational output decoder feeding the memory controller. Accepts pixel writes from N_ENGINES draw engines over per-engine valid/ready handshakes, arbitrates round-robin, and buffers granted pixels in a FIFO toward the memory controller. Orders frame flushes behind all pending pixels, so engines may run concurrently without a decoder-side priority scheme.

Parameters:
N_ENGINES, 4, number of draw-engine request ports (>=2)
X_BITS, 10, x coordinate width
Y_BITS, 9, y coordinate width
CHAN_BITS, 8, bits per colour channel; pixel colour = 3*CHAN_BITS
DEPTH, 8, pixel FIFO entries (power of two, >=2)
X_MAX, 639, largest legal x (used by clip feature)
Y_MAX, 479, largest legal y (used by clip feature)

Ports:
clk  in  1  system clock
n_rst  in  1  asynchronous active-low reset
req_valid_i  in  N_ENGINES  engine i has a pixel
req_x_i  in  N_ENGINES*X_BITS  packed x, engine i at [i*X_BITS +: X_BITS]
req_y_i  in  N_ENGINES*Y_BITS  packed y
req_rgb_i  in  N_ENGINES*3*CHAN_BITS  packed {r,g,b}
req_ready_o  out  N_ENGINES  one-hot grant; transfer when valid&ready
flush_i  in  1  single-cycle frame-flush request from controller
pix_valid_o  out  1  FIFO head valid
pix_ready_i  in  1  memory controller accepts head
pix_x_o  out  X_BITS  head x
pix_y_o  out  Y_BITS  head y
pix_rgb_o  out  3*CHAN_BITS  head colour
flush_o  out  1  one-cycle flush to memory controller, after drain
busy_o  out  1  FIFO non-empty or state != RUN
fifo_count_o  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset (async, n_rst=0): FIFO empty, rr pointer=0, state RUN; req_ready_o=0, pix_valid_o=0, pix_x/y/rgb_o=0, flush_o=0, busy_o=0, fifo_count_o=0.
- Arbitration (RUN only): search starts at rr pointer, wraps modulo N_ENGINES; first engine with valid is granted. Grant only if count<DEPTH, or count==DEPTH and a pop occurs this cycle. req_ready_o combinational from registered state and current valids; at most one bit set.
- After a grant to engine k, rr pointer <= (k+1) mod N_ENGINES; no grant -> pointer unchanged.
- FIFO: push on grant, pop on pix_valid_o&pix_ready_i; simultaneous push/pop keeps count. Head outputs from storage at read pointer; pushed pixel visible on pix_valid_o the cycle after acceptance (latency 1). Head data hold stable while valid&!ready. Pointers wrap at DEPTH.
- States: RUN -> DRAIN on flush_i. DRAIN: no grants (req_ready_o=0); pops continue. DRAIN -> FLUSH when count==0. FLUSH: flush_o=1 for exactly one cycle, -> RUN. flush_i seen in DRAIN or FLUSH is merged (ignored, no second flush_o).
- flush_i in the same cycle as a grant: the grant completes and its pixel precedes the flush.
- Engines must hold valid/data until granted; an unchanged request is never lost or duplicated.
- Reset mid-drain: FIFO contents discarded, no flush_o.

Optional Feature:
GPU_PIXEL_CLIP_EN: when defined, a granted pixel with x>X_MAX or y>Y_MAX is accepted (ready asserted, rr advances) but not pushed. Adds output clip_count_o (16 bits), saturating count of dropped pixels, reset 0, cleared on flush_o. When undefined, all pixels are pushed and the port is absent.

Decomposition:
- Shared package gpu_pkg holds: pixel struct typedef {x,y,r,g,b}, arbiter state enum {RUN,DRAIN,FLUSH}, and default X_MAX/Y_MAX constants.
- One sub-module: gpu_pixel_fifo (parametrised synchronous FIFO, DEPTH x pixel, push/pop/count).
- The round-robin search stays inline.

Test Plan:
- All 4 engines valid continuously, pix_ready_i=1 -> grants in order 0,1,2,3,0,... one per cycle; output order matches; each pixel appears 1 cycle after grant.
- pix_ready_i=0, engine 2 sends 9 pixels, DEPTH=8 -> 8 accepted, fifo_count_o=8, req_ready_o=0 on the 9th until pix_ready_i=1; then same-cycle push/pop holds count at 8.
- 5 pixels buffered, flush_i pulse, engines still valid -> no grants until 5 pops, then flush_o high exactly 1 cycle, grants resume the next cycle.
- flush_i coincident with grant of (100,50,rgb 0xFF00FF) -> that pixel is output before flush_o; a second flush_i during DRAIN yields a single flush_o.
- n_rst asserted with 3 pixels queued mid-DRAIN -> all outputs 0 immediately, no flush_o after release, state RUN.
- GPU_PIXEL_CLIP_EN: pixels (640,0), (0,480), (639,479) -> first two dropped, clip_count_o=2, only (639,479) output; clip_count_o=0 after flush_o.
